// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment codes,
// special nibble values and the capture FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] NIBBLE_BLANK   = 4'hF;
    localparam logic [3:0] NIBBLE_INVALID = 4'hE;

    typedef enum logic [1:0] {
        S_WAIT,
        S_STABLE,
        S_HOLD
    } state_t;

    // Forward encoding, shared with the display driver side.
    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        logic [6:0] pat;
        unique case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to BCD nibble decoder.
// Unknown patterns map to NIBBLE_INVALID and raise invalid.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       invalid
);

    always_comb begin
        nibble  = NIBBLE_INVALID;
        invalid = 1'b0;
        unique case (pattern)
            SEG_0:     nibble = 4'd0;
            SEG_1:     nibble = 4'd1;
            SEG_2:     nibble = 4'd2;
            SEG_3:     nibble = 4'd3;
            SEG_4:     nibble = 4'd4;
            SEG_5:     nibble = 4'd5;
            SEG_6:     nibble = 4'd6;
            SEG_7:     nibble = 4'd7;
            SEG_8:     nibble = 4'd8;
            SEG_9:     nibble = 4'd9;
            SEG_BLANK: nibble = NIBBLE_BLANK;
            default: begin
                nibble  = NIBBLE_INVALID;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_seg_frame_decoder.sv
// Snoops a multiplexed active-low seven-segment bus and recovers
// one nibble plus decimal point per digit, published per frame.
module seven_seg_frame_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    digit_err
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [7:0]            s_seg;
    logic [NUM_DIGITS-1:0] s_an;
    logic [7:0]            ref_seg;
    logic [NUM_DIGITS-1:0] ref_an;
    state_t                state;
    logic [CNT_W-1:0]      cnt;

    logic [3:0]            slot_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] slot_dp;
    logic [NUM_DIGITS-1:0] slot_err;
    logic [NUM_DIGITS-1:0] mask;

    logic [NUM_DIGITS-1:0] sel;
    logic                  onehot;
    logic                  same;
    logic                  capture;
    logic                  frame_full;
    logic [3:0]            dec_nib;
    logic                  dec_inv;

    seg7_pattern_decode u_decode (
        .pattern (ref_seg[6:0]),
        .nibble  (dec_nib),
        .invalid (dec_inv)
    );

    // Exactly one anode driven low selects a digit.
    assign sel        = ~s_an;
    assign onehot     = (|sel) && ((sel & (sel - AN_ONE)) == '0);
    assign same       = (s_seg == ref_seg) && (s_an == ref_an);
    assign capture    = (state == S_STABLE) && same && (cnt == CNT_LAST);
    assign frame_full = &mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg       <= '1;
            s_an        <= '1;
            ref_seg     <= '1;
            ref_an      <= '1;
            state       <= S_WAIT;
            cnt         <= '0;
            slot_dp     <= '0;
            slot_err    <= '0;
            mask        <= '0;
            digits_out  <= '1;
            dp_out      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            digit_err   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_nib[i] <= NIBBLE_BLANK;
            end
        end else begin
            s_seg       <= seg_in;
            s_an        <= an_in;
            digit_err   <= capture & dec_inv;
            frame_valid <= frame_full;
            frame_err   <= frame_full & (|slot_err);

            if (frame_full) begin
                dp_out <= slot_dp;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digits_out[4*i +: 4] <= slot_nib[i];
                end
            end

            // A capture on the publish edge lands in the fresh frame.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (frame_full) begin
                    mask[i]     <= 1'b0;
                    slot_err[i] <= 1'b0;
                end
                if (capture && !ref_an[i]) begin
                    mask[i]     <= 1'b1;
                    slot_err[i] <= dec_inv;
                    slot_nib[i] <= dec_nib;
                    slot_dp[i]  <= ~ref_seg[7];
                end
            end

            unique case (state)
                S_WAIT: begin
                    if (onehot) begin
                        ref_seg <= s_seg;
                        ref_an  <= s_an;
                        cnt     <= CNT_ONE;
                        state   <= S_STABLE;
                    end
                end
                S_STABLE, S_HOLD: begin
                    if (!same) begin
                        if (onehot) begin
                            ref_seg <= s_seg;
                            ref_an  <= s_an;
                            cnt     <= CNT_ONE;
                            state   <= S_STABLE;
                        end else begin
                            cnt   <= '0;
                            state <= S_WAIT;
                        end
                    end else if (state == S_STABLE) begin
                        cnt <= cnt + CNT_ONE;
                        if (capture) begin
                            state <= S_HOLD;
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_frame_decoder.sv
// Directed bench for seven_seg_frame_decoder: scans digits on the
// multiplexed bus and checks published frames against hand values.
module tb_seven_seg_frame_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits_out;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        frame_err;
    logic        digit_err;

    int compared   = 0;
    int mismatched = 0;
    int fv_cnt     = 0;
    int de_cnt     = 0;
    logic last_ferr = 1'b0;
    int f0;
    int d0;

    logic [6:0] pat [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    logic [6:0] blank_pat = 7'b1111111;
    logic [6:0] bad_pat   = 7'b0101010;

    always #5 clk = ~clk;

    seven_seg_frame_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits_out  (digits_out),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .digit_err   (digit_err)
    );

    always @(posedge clk) begin
        #1;
        if (frame_valid) begin
            fv_cnt++;
            last_ferr = frame_err;
        end
        if (digit_err) de_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input int d, input logic [6:0] p,
                        input logic dp, input int n);
        an_in  = ~(4'(1) << d);
        seg_in = {~dp, p};
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        an_in  = 4'hF;
        seg_in = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        an_in  = 4'hF;
        seg_in = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(digits_out), 32'hFFFF);
        chk("rst_dp", 32'(dp_out), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_derr", 32'(digit_err), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Basic scan 1,2,3,4 with dp on digit 2
        f0 = fv_cnt;
        d0 = de_cnt;
        show(0, pat[1], 1'b0, 10);
        show(1, pat[2], 1'b0, 10);
        show(2, pat[3], 1'b1, 10);
        show(3, pat[4], 1'b0, 10);
        idle(4);
        chk("t1_fv", 32'(fv_cnt - f0), 32'd1);
        chk("t1_digits", 32'(digits_out), 32'h4321);
        chk("t1_dp", 32'(dp_out), 32'h4);
        chk("t1_ferr", 32'(last_ferr), 32'h0);
        chk("t1_derr", 32'(de_cnt - d0), 32'd0);

        // Stability boundary: 7 cycles rejected, 8 accepted
        f0 = fv_cnt;
        show(0, pat[5], 1'b0, 10);
        show(1, pat[5], 1'b0, 10);
        show(2, pat[5], 1'b0, 10);
        show(3, pat[6], 1'b0, 7);
        idle(20);
        chk("t2_short", 32'(fv_cnt - f0), 32'd0);
        show(3, pat[6], 1'b0, 8);
        an_in  = 4'hF;
        seg_in = 8'hFF;
        @(negedge clk);
        chk("t2_e8_nofv", 32'(frame_valid), 32'h0);
        @(negedge clk);
        chk("t2_e9_fv", 32'(frame_valid), 32'h1);
        idle(3);
        chk("t2_fv", 32'(fv_cnt - f0), 32'd1);
        chk("t2_digits", 32'(digits_out), 32'h6555);

        // Blank and invalid patterns
        f0 = fv_cnt;
        d0 = de_cnt;
        show(0, pat[5], 1'b0, 10);
        show(1, blank_pat, 1'b0, 10);
        show(2, pat[5], 1'b0, 10);
        show(3, bad_pat, 1'b0, 10);
        idle(4);
        chk("t3_derr", 32'(de_cnt - d0), 32'd1);
        chk("t3_fv", 32'(fv_cnt - f0), 32'd1);
        chk("t3_digits", 32'(digits_out), 32'hE5F5);
        chk("t3_ferr", 32'(last_ferr), 32'h1);
        chk("t3_dp", 32'(dp_out), 32'h0);

        // Anode faults inside a frame
        f0 = fv_cnt;
        show(0, pat[0], 1'b0, 10);
        show(1, pat[1], 1'b0, 10);
        an_in  = 4'h0;
        seg_in = {1'b1, pat[8]};
        repeat (20) @(negedge clk);
        an_in = 4'hF;
        repeat (20) @(negedge clk);
        chk("t4_nofv", 32'(fv_cnt - f0), 32'd0);
        show(2, pat[2], 1'b0, 10);
        show(3, pat[3], 1'b0, 10);
        idle(4);
        chk("t4_fv", 32'(fv_cnt - f0), 32'd1);
        chk("t4_digits", 32'(digits_out), 32'h3210);
        chk("t4_ferr", 32'(last_ferr), 32'h0);

        // Re-capture of digit 0 before frame completes
        f0 = fv_cnt;
        show(0, pat[7], 1'b0, 10);
        show(0, pat[9], 1'b0, 10);
        show(1, pat[1], 1'b0, 10);
        show(2, pat[2], 1'b0, 10);
        show(3, pat[3], 1'b1, 10);
        idle(4);
        chk("t5_fv", 32'(fv_cnt - f0), 32'd1);
        chk("t5_digits", 32'(digits_out), 32'h3219);
        chk("t5_dp", 32'(dp_out), 32'h8);

        // Reset mid-frame
        f0 = fv_cnt;
        show(0, pat[1], 1'b0, 10);
        show(1, pat[2], 1'b0, 10);
        show(2, pat[3], 1'b0, 10);
        rst_n = 1'b0;
        idle(2);
        chk("t6_rst_digits", 32'(digits_out), 32'hFFFF);
        chk("t6_rst_dp", 32'(dp_out), 32'h0);
        chk("t6_rst_fv", 32'(frame_valid), 32'h0);
        chk("t6_rst_ferr", 32'(frame_err), 32'h0);
        chk("t6_rst_derr", 32'(digit_err), 32'h0);
        rst_n = 1'b1;
        idle(2);
        chk("t6_abort", 32'(fv_cnt - f0), 32'd0);
        show(0, pat[8], 1'b0, 10);
        show(1, pat[8], 1'b0, 10);
        show(2, pat[8], 1'b0, 10);
        chk("t6_early", 32'(fv_cnt - f0), 32'd0);
        show(3, pat[8], 1'b0, 10);
        idle(4);
        chk("t6_fv", 32'(fv_cnt - f0), 32'd1);
        chk("t6_digits", 32'(digits_out), 32'h8888);
        chk("t6_ferr", 32'(last_ferr), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seven_seg_frame_decoder.md
Name: seven_seg_frame_decoder

Overview:
- Receive-side counterpart of the BCD-to-seven-segment encoding. The block snoops a multiplexed, active-low display bus (segment lines plus anode selects) and recovers one BCD nibble and one decimal-point bit per digit.
- It publishes a complete frame once every digit position has been captured.
- Uses: display loopback checking on the board, and a self-check monitor in simulation.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (anode lines).
- STABLE_CYCLES, 8, consecutive identical samples required before a digit is accepted (range 2..255).
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  8  segment bus, active-low; bit7 = dp, bits6..0 = g..a.
- an_in  in  NUM_DIGITS  anode selects, active-low; exactly one low selects a digit.
- digits_out  out  4*NUM_DIGITS  recovered nibbles; digit i at bits [4i+3:4i].
- dp_out  out  NUM_DIGITS  recovered decimal points, active-high (dp_out[i] = ~seg bit7).
- frame_valid  out  1  one-cycle pulse; digits_out and dp_out updated in the same cycle.
- frame_err  out  1  valid only with frame_valid; 1 if any slot in the frame decoded invalid.
- digit_err  out  1  one-cycle pulse when a captured pattern is invalid.

Behaviour:
- Reset (async assert; deassertion takes effect on the next clk edge):
  - digits_out = all 4'hF; dp_out = 0.
  - frame_valid, frame_err, digit_err = 0.
  - capture mask = 0; FSM = S_WAIT; counter = 0; sample registers = all 1s.
- Reset mid-frame discards partial captures. No output pulse is produced for the discarded frame.
- Input stage: seg_in and an_in are registered once (s_seg, s_an). An inputs synchronizer, if needed, is the integrator's responsibility.
- Decode table, applied to bits6..0:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4.
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - 1111111 (blank)→F.
  - Any other pattern→E, and the pattern counts as invalid.
- FSM:
  - S_WAIT: s_an one-hot-low → latch (s_an, s_seg) as reference, counter = 1, go to S_STABLE. Otherwise stay.
  - S_STABLE, sample equal to the reference: counter increments.
  - S_STABLE, sample differs: if the new sample is one-hot, re-latch and set counter = 1; else go to S_WAIT.
  - S_STABLE, counter reaching STABLE_CYCLES: write the slot selected by the reference, set its mask bit, pulse digit_err if invalid, go to S_HOLD.
  - S_HOLD: any change from the reference → same handling as a mismatch in S_STABLE. Identical samples never re-capture.
- Latency: first sample registered at edge E0 → slot written at edge E0+STABLE_CYCLES. This assumes an uninterrupted run.
- Anode faults: all anodes high, or more than one low, is never captured and resets stability (→ S_WAIT).
- Re-capture of an already-masked digit before the frame completes overwrites the slot and its error bit. The latest capture wins.
- Frame completion:
  - Trigger: the slot write that makes the mask all ones.
  - On the next edge: digits_out and dp_out load all slots, frame_valid = 1, frame_err = OR of slot error bits.
  - On that same edge: mask and slot error bits clear.
- Simultaneous events: a capture on the same edge that publishes a frame lands in the new (cleared) frame. Mask clear and the new bit set occur together, with the set taking priority.
- Between frames, digits_out and dp_out hold their last published value.

Decomposition:
- Shared package seg7_pkg:
  - Active-low segment code constants SEG_0..SEG_9 and SEG_BLANK. The existing encoder moves to these constants too.
  - NIBBLE_BLANK = 4'hF, NIBBLE_INVALID = 4'hE.
  - FSM state typedef (S_WAIT, S_STABLE, S_HOLD).
- One sub-module: seg7_pattern_decode, a combinational 7-bit pattern → {invalid, nibble[3:0]}. It is reusable by the bench scoreboard.
- Stability FSM, slot registers and frame logic stay in the top.

Test Plan:
- Default params; scan digits 0..3 showing 1,2,3,4 (dp on digit 2), 10 cycles each → one frame_valid with digits_out = 16'h4321, dp_out = 4'b0100, frame_err = 0, digit_err never pulses.
- Digit held exactly STABLE_CYCLES−1 = 7 cycles then anode switched → no capture and no frame. At 8 cycles → captured, with the write on edge E0+8.
- Digit 1 driven 7'b1111111 and digit 3 driven 7'b0101010, others 5 → digit_err pulses once (digit 3); frame_valid with digits_out = 16'hE5F5, frame_err = 1.
- an_in = 4'b0000 and 4'b1111 for 20 cycles each inside a frame → no capture, mask unchanged. Scanning then resumes and completes the frame normally.
- Digit 0 shows 7, then (before other digits) shows 9 for 8+ cycles, then the remaining digits complete → published digit 0 = 9.
- rst_n asserted after 3 of 4 digits captured, released, then full scan of 8,8,8,8 → single frame_valid with 16'h8888; no pulse from the aborted frame; during reset outputs equal the reset values.
